// File: rtl/floppy_pkg.sv
// floppy_pkg: shared definitions for the emulated floppy drive head path.
//   COIL_PH0..COIL_PH3 : one-hot stepper coil phases, inward order
//   step_kind_e        : decoded step classification per cycle
//   MAX_TRACK_DEFAULT  : default highest reachable track
package floppy_pkg;

   localparam logic [3:0] COIL_PH0 = 4'b0001;
   localparam logic [3:0] COIL_PH1 = 4'b0010;
   localparam logic [3:0] COIL_PH2 = 4'b0100;
   localparam logic [3:0] COIL_PH3 = 4'b1000;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_IN,
      STEP_OUT,
      STEP_BAD
   } step_kind_e;

   localparam int unsigned MAX_TRACK_DEFAULT = 79;

endpackage

// File: rtl/head_position_tracker_if.sv
// head_position_tracker_if: coil input and head status outputs of the tracker.
//   coils      : one-hot coil phase from the stepper driver
//   track      : current whole-track position
//   tr0        : head at track 0, sub-step 0
//   step_event : one-cycle pulse per accepted step
//   step_dir   : direction of last accepted step (0 inward, 1 outward)
//   limit_hit  : one-cycle pulse when a step is rejected at a bound
//   settled    : no step in the last SETTLE_CYCLES cycles
//   fault      : sticky illegal-pattern / phase-jump flag
// master = driver/consumer side, slave = tracker side.
interface head_position_tracker_if #(
   parameter int unsigned TRACK_W = 7
) ();

   logic [3:0]         coils;
   logic [TRACK_W-1:0] track;
   logic               tr0;
   logic               step_event;
   logic               step_dir;
   logic               limit_hit;
   logic               settled;
   logic               fault;

   modport master (
      output coils,
      input  track, tr0, step_event, step_dir, limit_hit, settled, fault
   );

   modport slave (
      input  coils,
      output track, tr0, step_event, step_dir, limit_hit, settled, fault
   );

endinterface

// File: rtl/coil_step_decode.sv
// coil_step_decode: combinational classification of a coil phase change.
//   prev_i : last legal one-hot phase
//   coils_i: current coil pattern
//   kind_o : STEP_NONE (equal), STEP_IN (next phase), STEP_OUT (previous phase),
//            STEP_BAD (non-one-hot or opposite phase)
module coil_step_decode
   import floppy_pkg::*;
(
   input  logic [3:0] prev_i,
   input  logic [3:0] coils_i,
   output step_kind_e kind_o
);

   always_comb begin
      kind_o = STEP_BAD;
      if (!$onehot(coils_i)) begin
         kind_o = STEP_BAD;
      end else if (coils_i == prev_i) begin
         kind_o = STEP_NONE;
      end else if (coils_i == {prev_i[2:0], prev_i[3]}) begin
         kind_o = STEP_IN;
      end else if (coils_i == {prev_i[0], prev_i[3:1]}) begin
         kind_o = STEP_OUT;
      end else begin
         // Only the opposite phase remains: a two-phase jump.
         kind_o = STEP_BAD;
      end
   end

endmodule

// File: rtl/head_position_tracker.sv
// head_position_tracker: virtual head position of the emulated floppy drive.
//   clk : system clock
//   rst : synchronous reset, active-low
//   bus : head_position_tracker_if slave (coils in; track, tr0, step_event,
//         step_dir, limit_hit, settled, fault out)
// Coil phase advances move a fine position (track*STEPS_PER_TRACK + substep)
// that saturates at 0 and MAX_TRACK*STEPS_PER_TRACK. Outputs update one edge
// after the coils change.
module head_position_tracker
   import floppy_pkg::*;
#(
   parameter int unsigned STEPS_PER_TRACK = 1,
   parameter int unsigned MAX_TRACK       = MAX_TRACK_DEFAULT,
   parameter int unsigned SETTLE_CYCLES   = 1000,
   parameter int unsigned TRACK_W         = 7
) (
   input logic                  clk,
   input logic                  rst,
   head_position_tracker_if.slave bus
);

   localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0]         SubMax     = 2'(STEPS_PER_TRACK - 1);
   localparam logic [TRACK_W-1:0] TrackMax   = TRACK_W'(MAX_TRACK);
   localparam logic [CntW-1:0]    SettleLoad = CntW'(SETTLE_CYCLES);

   logic [3:0]         prev_d, prev_q;
   logic [1:0]         substep_d, substep_q;
   logic [TRACK_W-1:0] track_d, track_q;
   logic [CntW-1:0]    settle_cnt_d, settle_cnt_q;
   logic               fault_d, fault_q;
   logic               step_dir_d, step_dir_q;
   logic               step_event_d, step_event_q;
   logic               limit_hit_d, limit_hit_q;

   step_kind_e kind;
   logic       at_floor;
   logic       at_ceiling;

   coil_step_decode u_decode (
      .prev_i (prev_q),
      .coils_i(bus.coils),
      .kind_o (kind)
   );

   assign at_floor   = (track_q == '0) && (substep_q == 2'd0);
   assign at_ceiling = (track_q == TrackMax) && (substep_q == 2'd0);

   always_comb begin
      prev_d       = prev_q;
      substep_d    = substep_q;
      track_d      = track_q;
      fault_d      = fault_q;
      step_dir_d   = step_dir_q;
      step_event_d = 1'b0;
      limit_hit_d  = 1'b0;
      settle_cnt_d = (settle_cnt_q != '0) ? settle_cnt_q - CntW'(1) : settle_cnt_q;

      // Opposite-phase jumps still resynchronise the decoder.
      if ($onehot(bus.coils)) begin
         prev_d = bus.coils;
      end

      unique case (kind)
         STEP_IN: begin
            if (at_ceiling) begin
               limit_hit_d = 1'b1;
            end else begin
               step_event_d = 1'b1;
               step_dir_d   = 1'b0;
               settle_cnt_d = SettleLoad;
               if (substep_q == SubMax) begin
                  substep_d = 2'd0;
                  track_d   = track_q + TRACK_W'(1);
               end else begin
                  substep_d = substep_q + 2'd1;
               end
            end
         end
         STEP_OUT: begin
            if (at_floor) begin
               limit_hit_d = 1'b1;
            end else begin
               step_event_d = 1'b1;
               step_dir_d   = 1'b1;
               settle_cnt_d = SettleLoad;
               if (substep_q == 2'd0) begin
                  substep_d = SubMax;
                  track_d   = track_q - TRACK_W'(1);
               end else begin
                  substep_d = substep_q - 2'd1;
               end
            end
         end
         STEP_BAD: begin
            fault_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_q       <= COIL_PH0;
         substep_q    <= 2'd0;
         track_q      <= '0;
         settle_cnt_q <= '0;
         fault_q      <= 1'b0;
         step_dir_q   <= 1'b0;
         step_event_q <= 1'b0;
         limit_hit_q  <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         substep_q    <= substep_d;
         track_q      <= track_d;
         settle_cnt_q <= settle_cnt_d;
         fault_q      <= fault_d;
         step_dir_q   <= step_dir_d;
         step_event_q <= step_event_d;
         limit_hit_q  <= limit_hit_d;
      end
   end

   assign bus.track      = track_q;
   assign bus.tr0        = at_floor;
   assign bus.step_event = step_event_q;
   assign bus.step_dir   = step_dir_q;
   assign bus.limit_hit  = limit_hit_q;
   assign bus.settled    = (settle_cnt_q == '0);
   assign bus.fault      = fault_q;

endmodule

// File: tb/tb_head_position_tracker.sv
// tb_head_position_tracker: two tracker instances (1 and 2 steps per track)
// checked every cycle against a fine-position reference model, plus directed
// checks of the documented scenarios against fixed expected values.
module tb_head_position_tracker;

   localparam int unsigned SA = 1;
   localparam int unsigned MA = 79;
   localparam int unsigned TA = 10;
   localparam int unsigned SB = 2;
   localparam int unsigned MB = 5;
   localparam int unsigned TB = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;

   head_position_tracker_if #(.TRACK_W(7)) if_a ();
   head_position_tracker_if #(.TRACK_W(7)) if_b ();

   head_position_tracker #(
      .STEPS_PER_TRACK(SA),
      .MAX_TRACK      (MA),
      .SETTLE_CYCLES  (TA),
      .TRACK_W        (7)
   ) u_dut_a (
      .clk(clk),
      .rst(rst),
      .bus(if_a)
   );

   head_position_tracker #(
      .STEPS_PER_TRACK(SB),
      .MAX_TRACK      (MB),
      .SETTLE_CYCLES  (TB),
      .TRACK_W        (7)
   ) u_dut_b (
      .clk(clk),
      .rst(rst),
      .bus(if_b)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: phase index 0..3 and an integer fine position.
   int m_phase[2];
   int m_fine[2];
   int m_settle[2];
   bit m_fault[2];
   bit m_dir[2];
   bit m_ev[2];
   bit m_lim[2];

   function automatic int p_steps(int i);
      return (i == 0) ? int'(SA) : int'(SB);
   endfunction

   function automatic int p_max(int i);
      return (i == 0) ? int'(MA) : int'(MB);
   endfunction

   function automatic int p_settle(int i);
      return (i == 0) ? int'(TA) : int'(TB);
   endfunction

   function automatic logic [3:0] ph(int k);
      logic [3:0] one;
      one = 4'b0001;
      return one << (k % 4);
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int i);
      m_phase[i]  = 0;
      m_fine[i]   = 0;
      m_settle[i] = 0;
      m_fault[i]  = 1'b0;
      m_dir[i]    = 1'b0;
      m_ev[i]     = 1'b0;
      m_lim[i]    = 1'b0;
   endtask

   task automatic model_edge(input int i, input logic [3:0] c, input logic r);
      int ci;
      int d;
      if (!r) begin
         model_reset(i);
         return;
      end
      m_ev[i]  = 1'b0;
      m_lim[i] = 1'b0;
      if (m_settle[i] > 0) m_settle[i]--;
      if (!$onehot(c)) begin
         m_fault[i] = 1'b1;
         return;
      end
      ci = 0;
      for (int k = 0; k < 4; k++) if (c[k]) ci = k;
      d = (ci - m_phase[i] + 4) % 4;
      m_phase[i] = ci;
      if (d == 1) begin
         if (m_fine[i] == p_max(i) * p_steps(i)) begin
            m_lim[i] = 1'b1;
         end else begin
            m_fine[i]++;
            m_ev[i] = 1'b1; m_dir[i] = 1'b0; m_settle[i] = p_settle(i);
         end
      end else if (d == 3) begin
         if (m_fine[i] == 0) begin
            m_lim[i] = 1'b1;
         end else begin
            m_fine[i]--;
            m_ev[i] = 1'b1; m_dir[i] = 1'b1; m_settle[i] = p_settle(i);
         end
      end else if (d == 2) begin
         m_fault[i] = 1'b1;
      end
   endtask

   task automatic compare_one(input string p, input int i, input int trk, input bit tr0,
                              input bit ev, input bit dir, input bit lim, input bit stl,
                              input bit flt);
      check_eq({p, ".track"}, trk, m_fine[i] / p_steps(i));
      check_eq({p, ".tr0"}, int'(tr0), int'(m_fine[i] == 0));
      check_eq({p, ".step_event"}, int'(ev), int'(m_ev[i]));
      check_eq({p, ".step_dir"}, int'(dir), int'(m_dir[i]));
      check_eq({p, ".limit_hit"}, int'(lim), int'(m_lim[i]));
      check_eq({p, ".settled"}, int'(stl), int'(m_settle[i] == 0));
      check_eq({p, ".fault"}, int'(flt), int'(m_fault[i]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0, if_a.coils, rst);
      model_edge(1, if_b.coils, rst);
      #1;
      compare_one("a", 0, int'(if_a.track), if_a.tr0, if_a.step_event, if_a.step_dir,
                  if_a.limit_hit, if_a.settled, if_a.fault);
      compare_one("b", 1, int'(if_b.track), if_b.tr0, if_b.step_event, if_b.step_dir,
                  if_b.limit_hit, if_b.settled, if_b.fault);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      if_a.coils = 4'b0001;
      if_b.coils = 4'b0001;
      tick();
      rst = 1'b1;
   endtask

   function automatic logic [3:0] rand_coils(int phase);
      int r;
      r = int'($urandom_range(0, 15));
      if (r <= 5) return ph(phase + 1);
      if (r <= 9) return ph(phase + 3);
      if (r == 13) return 4'($urandom_range(0, 15));
      if (r == 14) return ph(phase + 2);
      return ph(phase);
   endfunction

   initial begin
      model_reset(0);
      model_reset(1);
      if_a.coils = 4'b0001;
      if_b.coils = 4'b0001;
      do_reset();
      check_eq("rst.track", int'(if_a.track), 0);
      check_eq("rst.tr0", int'(if_a.tr0), 1);
      check_eq("rst.settled", int'(if_a.settled), 1);

      // Four inward phases, one every other cycle.
      tick();
      for (int k = 1; k <= 4; k++) begin
         if_a.coils = ph(k);
         tick();
         check_eq("seq.event", int'(if_a.step_event), 1);
         check_eq("seq.track", int'(if_a.track), k);
         tick();
      end
      check_eq("seq.tr0", int'(if_a.tr0), 0);
      check_eq("seq.dir", int'(if_a.step_dir), 0);

      // Outward from track 0 is rejected.
      do_reset();
      if_a.coils = 4'b1000;
      tick();
      check_eq("floor.limit", int'(if_a.limit_hit), 1);
      check_eq("floor.event", int'(if_a.step_event), 0);
      check_eq("floor.tr0", int'(if_a.tr0), 1);
      check_eq("floor.settled", int'(if_a.settled), 1);
      tick();
      check_eq("floor.limit1", int'(if_a.limit_hit), 0);

      // Climb to the top track, then one step too far.
      do_reset();
      for (int k = 1; k <= 80; k++) begin
         if_a.coils = ph(k);
         tick();
      end
      check_eq("ceil.limit", int'(if_a.limit_hit), 1);
      check_eq("ceil.track", int'(if_a.track), 79);

      // Settle window and its extension by a second step.
      do_reset();
      if_a.coils = ph(1);
      tick();
      check_eq("settle.low0", int'(if_a.settled), 0);
      repeat (9) tick();
      check_eq("settle.low9", int'(if_a.settled), 0);
      tick();
      check_eq("settle.high", int'(if_a.settled), 1);
      if_a.coils = ph(2);
      tick();
      repeat (6) tick();
      if_a.coils = ph(3);
      tick();
      repeat (9) tick();
      check_eq("settle.ext_low", int'(if_a.settled), 0);
      tick();
      check_eq("settle.ext_high", int'(if_a.settled), 1);

      // Illegal patterns, then a normal step, then reset mid-settle.
      do_reset();
      if_a.coils = 4'b0011;
      tick();
      check_eq("bad.fault", int'(if_a.fault), 1);
      check_eq("bad.track", int'(if_a.track), 0);
      if_a.coils = 4'b0100;
      tick();
      check_eq("jump.fault", int'(if_a.fault), 1);
      check_eq("jump.event", int'(if_a.step_event), 0);
      if_a.coils = 4'b1000;
      tick();
      check_eq("after.track", int'(if_a.track), 1);
      tick();
      rst = 1'b0;
      if_a.coils = 4'b0001;
      tick();
      check_eq("midrst.track", int'(if_a.track), 0);
      check_eq("midrst.settled", int'(if_a.settled), 1);
      check_eq("midrst.fault", int'(if_a.fault), 0);
      rst = 1'b1;

      // Two steps per track.
      do_reset();
      if_b.coils = 4'b0010;
      tick();
      check_eq("sub.track0", int'(if_b.track), 0);
      check_eq("sub.tr0_a", int'(if_b.tr0), 0);
      if_b.coils = 4'b0100;
      tick();
      check_eq("sub.track1", int'(if_b.track), 1);
      if_b.coils = 4'b0010;
      tick();
      check_eq("sub.back", int'(if_b.track), 0);
      check_eq("sub.tr0_b", int'(if_b.tr0), 0);
      if_b.coils = 4'b0001;
      tick();
      check_eq("sub.tr0_c", int'(if_b.tr0), 1);

      // Randomized traffic on both instances.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         if_a.coils = rand_coils(m_phase[0]);
         if_b.coils = rand_coils(m_phase[1]);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
